// File: rtl/alu_pkg.sv
// Shared opcode encoding and sequencer state encoding for the 8-bit ALU
// datapath and the issue/capture sequencer wrapped around it.
package alu_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_INV  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;
  localparam logic [3:0] OP_LAST = OP_SHR;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  // Codes above the last defined opcode are accepted but flagged as errors.
  function automatic logic op_illegal(input logic [3:0] op);
    return (op > OP_LAST);
  endfunction

endpackage

// File: rtl/alu_top.sv
// Combinational W-bit ALU: opcode mux over the package encoding.
// Arithmetic wraps at W bits; shifts are by one position, zero-filled.
// NOP and undefined codes produce zero.
module alu_top
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic [3:0]   op_s,
  output logic [W-1:0] result
);

  // Opcode-selected result, settles within one cycle of stable operands.
  always_comb begin
    result = '0;
    case (op_s)
      OP_NOP:  result = '0;
      OP_ADD:  result = op_a + op_b;
      OP_SUB:  result = op_a - op_b;
      OP_AND:  result = op_a & op_b;
      OP_OR:   result = op_a | op_b;
      OP_XOR:  result = op_a ^ op_b;
      OP_INV:  result = ~op_a;
      OP_SHL:  result = {op_a[W-2:0], 1'b0};
      OP_SHR:  result = {1'b0, op_a[W-1:1]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue/capture stage around the combinational ALU. Requests arrive over a
// valid/ready handshake, operands are held in registers that drive the ALU,
// and the settled result is captured with flags and offered downstream.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | in_ready=1, waiting for a request
// ST_EXEC | operands stable on the ALU, result captured at end of cycle
// ST_DONE | out_valid=1, result held until out_ready
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [3:0]       in_op,
  input  logic             in_use_acc,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [3:0]       alu_s,
  input  logic [W-1:0]     alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_result,
  output logic             out_zero,
  output logic             out_err,
  output logic [W-1:0]     acc,
  output logic [CNT_W-1:0] op_count
);

  seq_state_t state;

  logic         illegal;
  logic [W-1:0] capture;

  // Value to capture at the end of EXEC; illegal opcodes are forced to zero.
  always_comb begin
    illegal = op_illegal(alu_s);
    capture = illegal ? '0 : alu_result;
  end

  // Sequencer FSM with registered handshake, operand and result outputs.
  // The operand registers only load on accept, so the ALU inputs stay
  // frozen while a result is pending downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_err    <= 1'b0;
      acc        <= '0;
      op_count   <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_s      <= OP_NOP;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            alu_a    <= in_use_acc ? acc : in_a;
            alu_b    <= in_b;
            alu_s    <= in_op;
            in_ready <= 1'b0;
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          out_result <= capture;
          out_zero   <= (capture == '0);
          out_err    <= illegal;
          out_valid  <= 1'b1;
          state      <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            op_count  <= op_count + CNT_W'(1);
            // An errored op leaves the accumulator untouched for the chain.
            if (!out_err) begin
              acc <= out_result;
            end
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer driving the ALU datapath.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int W     = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [3:0]       in_op;
  logic             in_use_acc;
  logic [W-1:0]     alu_a;
  logic [W-1:0]     alu_b;
  logic [3:0]       alu_s;
  logic [W-1:0]     alu_result;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_result;
  logic             out_zero;
  logic             out_err;
  logic [W-1:0]     acc;
  logic [CNT_W-1:0] op_count;

  alu_op_sequencer #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_use_acc(in_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_err(out_err),
    .acc(acc), .op_count(op_count)
  );

  alu_top #(.W(W)) u_alu (
    .op_a(alu_a), .op_b(alu_b), .op_s(alu_s), .result(alu_result)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] m_acc;
  int           m_count;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       use_acc;
    int         stall;
    logic [7:0] exp_result;
    logic       exp_zero;
    logic       exp_err;
    logic [7:0] exp_acc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference semantics of the opcode set as plain arithmetic.
  function automatic logic [7:0] ref_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int r;
    case (int'(op))
      1: r = int'(a) + int'(b);
      2: r = int'(a) - int'(b);
      3: r = int'(a & b);
      4: r = int'(a | b);
      5: r = int'(a ^ b);
      6: r = 255 - int'(a);
      7: r = int'(a) * 2;
      8: r = int'(a) / 2;
      default: r = 0;
    endcase
    return 8'((r % 256 + 256) % 256);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_acc   = '0;
    m_count = 0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"},  in_ready,   1);
    chk({tag, "_out_valid"}, out_valid,  0);
    chk({tag, "_out_result"}, out_result, 0);
    chk({tag, "_out_zero"},  out_zero,   0);
    chk({tag, "_out_err"},   out_err,    0);
    chk({tag, "_acc"},       acc,        0);
    chk({tag, "_op_count"},  op_count,   0);
    chk({tag, "_alu_a"},     alu_a,      0);
    chk({tag, "_alu_b"},     alu_b,      0);
    chk({tag, "_alu_s"},     alu_s,      OP_NOP);
  endtask

  // One full transaction: accept, check EXEC, check latency/result, optional
  // backpressure with ignored requests, then the output handshake.
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic ua, input int stall, input string tag);
    logic [7:0] ea, er;
    logic       ez, ee;
    int         n;
    ea = ua ? m_acc : a;
    ee = (op > 4'd8);
    er = ee ? 8'h00 : ref_alu(op, ea, b);
    ez = (er == 8'h00);
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_wait_ready"}, in_ready, 1);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_use_acc = ua; out_ready = 1'b0;
    tick();
    in_valid = 1'b0; in_a = 8'($urandom); in_b = 8'($urandom);
    chk({tag, "_exec_valid"}, out_valid, 0);
    chk({tag, "_exec_ready"}, in_ready, 0);
    chk({tag, "_alu_a"}, alu_a, ea);
    chk({tag, "_alu_b"}, alu_b, b);
    chk({tag, "_alu_s"}, alu_s, op);
    tick();
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_result"}, out_result, er);
    chk({tag, "_zero"}, out_zero, ez);
    chk({tag, "_err"}, out_err, ee);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1; in_op = OP_ADD; in_use_acc = 1'b0;
      tick();
      chk({tag, "_stall_valid"}, out_valid, 1);
      chk({tag, "_stall_result"}, out_result, er);
      chk({tag, "_stall_ready"}, in_ready, 0);
      chk({tag, "_stall_alu_a"}, alu_a, ea);
      chk({tag, "_stall_count"}, op_count, 16'(m_count));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    if (!ee) m_acc = er;
    m_count++;
    chk({tag, "_post_valid"}, out_valid, 0);
    chk({tag, "_post_ready"}, in_ready, 1);
    chk({tag, "_acc"}, acc, m_acc);
    chk({tag, "_op_count"}, op_count, 16'(m_count));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepts;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = OP_NOP;
    in_use_acc = 1'b0; out_ready = 1'b0;
    tick(); tick();
    do_reset();
    tick();
    chk_reset_state("reset");

    // Directed table, applied in order so chained accumulator uses are valid.
    vecs.push_back('{OP_ADD, 8'h12, 8'h34, 1'b0, 0, 8'h46, 1'b0, 1'b0, 8'h46});
    vecs.push_back('{OP_ADD, 8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1, 1'b0, 8'h00});
    vecs.push_back('{OP_SUB, 8'h99, 8'h01, 1'b1, 0, 8'hFF, 1'b0, 1'b0, 8'hFF});
    vecs.push_back('{OP_SHR, 8'h00, 8'h00, 1'b1, 0, 8'h7F, 1'b0, 1'b0, 8'h7F});
    vecs.push_back('{OP_XOR, 8'hAA, 8'h0F, 1'b0, 5, 8'hA5, 1'b0, 1'b0, 8'hA5});
    vecs.push_back('{4'd12,  8'h55, 8'h11, 1'b0, 1, 8'h00, 1'b1, 1'b1, 8'hA5});
    vecs.push_back('{OP_AND, 8'hF0, 8'h3C, 1'b0, 0, 8'h30, 1'b0, 1'b0, 8'h30});
    vecs.push_back('{OP_OR,  8'h00, 8'h81, 1'b1, 2, 8'hB1, 1'b0, 1'b0, 8'hB1});
    vecs.push_back('{OP_INV, 8'h0F, 8'h00, 1'b0, 0, 8'hF0, 1'b0, 1'b0, 8'hF0});
    vecs.push_back('{OP_SHL, 8'h81, 8'h00, 1'b0, 0, 8'h02, 1'b0, 1'b0, 8'h02});
    vecs.push_back('{4'd15,  8'hFF, 8'hFF, 1'b1, 0, 8'h00, 1'b1, 1'b1, 8'h02});
    vecs.push_back('{OP_NOP, 8'h44, 8'h22, 1'b0, 0, 8'h00, 1'b1, 1'b0, 8'h00});
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].use_acc, vecs[i].stall, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_tbl_result", i), out_result, vecs[i].exp_result);
      chk($sformatf("vec%0d_tbl_zero", i), out_zero, vecs[i].exp_zero);
      chk($sformatf("vec%0d_tbl_err", i), out_err, vecs[i].exp_err);
      chk($sformatf("vec%0d_tbl_acc", i), acc, vecs[i].exp_acc);
    end

    // Seed a nonzero accumulator, then reset in the middle of EXEC.
    run_op(OP_ADD, 8'h20, 8'h03, 1'b0, 0, "pre_rst");
    in_valid = 1'b1; in_op = OP_ADD; in_a = 8'h11; in_b = 8'h22; in_use_acc = 1'b0;
    tick();
    chk("rst_exec_in_exec", in_ready, 0);
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    m_acc = '0; m_count = 0;
    chk_reset_state("rst_exec");
    tick();
    chk("rst_exec_no_result", out_valid, 0);

    // Reset while DONE with out_ready high: nothing must be delivered.
    in_valid = 1'b1; in_op = OP_SUB; in_a = 8'h09; in_b = 8'h02;
    tick();
    in_valid = 1'b0;
    tick();
    chk("rst_done_in_done", out_valid, 1);
    rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    chk_reset_state("rst_done");

    // Throughput: requests and out_ready held high complete one op per 3 cycles.
    in_valid = 1'b1; in_op = OP_ADD; in_a = 8'h01; in_b = 8'h01; in_use_acc = 1'b1;
    out_ready = 1'b1;
    accepts = 0;
    for (int i = 0; i < 9; i++) tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("tput_count", op_count, 3);
    chk("tput_acc", acc, 8'h03);
    chk("tput_idle", in_ready, 1);
    m_acc = 8'h03; m_count = 3;

    // Randomized transactions against the reference model.
    for (int i = 0; i < 60; i++) begin
      run_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Sequential issue/capture stage wrapped around the combinational 8-bit ALU top (opA, opB, opS -> Result).
- Accepts operation requests over a valid/ready handshake and registers the operands so the ALU sees stable inputs.
- Captures the ALU Result into an output register with status flags and presents it downstream over a second valid/ready handshake.
- Keeps an accumulator so operation chains can use the previous result as operand A.

Parameters:
- W, 8, operand/result width; must match the ALU datapath.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  sequencer can accept a request.
- in_a  in  W  operand A; ignored when in_use_acc=1.
- in_b  in  W  operand B.
- in_op  in  4  opcode (package encoding).
- in_use_acc  in  1  source operand A from accumulator.
- alu_a  out  W  to ALU opA.
- alu_b  out  W  to ALU opB.
- alu_s  out  4  to ALU opS.
- alu_result  in  W  from ALU Result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_result  out  W  captured result.
- out_zero  out  1  out_result == 0.
- out_err  out  1  request had an illegal opcode.
- acc  out  W  accumulator value.
- op_count  out  CNT_W  completed operations; wraps modulo 2^CNT_W.

Behaviour:
- Reset: state=IDLE. in_ready=1. out_valid=0. out_result=0. out_zero=0. out_err=0. acc=0. op_count=0. alu_a/alu_b=0. alu_s=OP_NOP.
- State IDLE: in_ready=1. On in_valid&&in_ready:
  - operand regs <- (in_use_acc ? acc : in_a), in_b, in_op.
  - go to EXEC.
- State EXEC: in_ready=0. alu_a/alu_b/alu_s are driven from the operand regs; the ALU settles within the cycle. At the end of the cycle:
  - out_result <- alu_result (legal opcode) or 0 (illegal opcode).
  - out_zero <- (captured value == 0).
  - out_err <- illegal.
  - go to DONE.
- State DONE: out_valid=1. Outputs stay stable until out_ready. On out_ready:
  - op_count increments.
  - acc <- out_result, legal ops only; acc is unchanged on an illegal op.
  - go to IDLE.
- Latency and throughput:
  - Accept at edge N, out_valid high from edge N+2.
  - With out_ready held at 1, one operation completes every 3 cycles.
- Operand registers hold their values outside EXEC, so the ALU inputs never glitch while a result is pending.
- Legal opcodes are 0..8: NOP, ADD, SUB, AND, OR, XOR, INV, SHL, SHR. Codes 9..15 are illegal. An illegal opcode is still accepted and completes normally, but with result 0 and err=1.
- Arithmetic is W-bit wrap-around (e.g. ADD 0xFF+0x01 = 0x00, zero=1). No carry or overflow flag: the ALU does not export one.
- Accumulator timing: in_use_acc sees the acc value committed at the previous out handshake, which is always complete before the next accept.
- Request inputs are ignored while in_ready=0; there is no buffering of requests.
- rst asserted in any state takes priority over all handshakes; the full reset state applies at the next edge and any in-flight operation is discarded.
- op_count wraps from 2^CNT_W-1 to 0.

Decomposition:
- Package alu_pkg:
  - localparams OP_NOP=4'd0, OP_ADD=4'd1, OP_SUB=4'd2, OP_AND=4'd3, OP_OR=4'd4, OP_XOR=4'd5, OP_INV=4'd6, OP_SHL=4'd7, OP_SHR=4'd8, OP_LAST=OP_SHR.
  - State encoding ST_IDLE, ST_EXEC, ST_DONE.
  - The same package is used by the ALU mux.
- No sub-module needed: a single FSM plus registers. The bench instantiates alu_op_sequencer together with the existing ALU top.

Test Plan:
- Reset then idle -> in_ready=1, out_valid=0, acc=0, op_count=0, alu_s=OP_NOP.
- ADD a=0x12 b=0x34, out_ready=1 -> out_valid exactly 2 cycles after accept, out_result=0x46, zero=0, acc=0x46, op_count=1.
- Chain: ADD 0xFF+0x01 -> 0x00, zero=1; then SUB use_acc=1 b=0x01 -> 0xFF; then SHR use_acc=1 -> 0x7F, acc=0x7F.
- Backpressure: hold out_ready=0 for 5 cycles after XOR 0xAA^0x0F -> out_result=0x00A5 stays stable, in_ready=0, new in_valid is ignored; release -> completes once, op_count+1.
- Illegal opcode 4'd12 with a=0x55 -> out_result=0, out_err=1, acc unchanged; next legal op has out_err=0.
- rst asserted during EXEC and again during DONE -> next cycle matches the full reset state, no result delivered, op_count=0.
